// File: rtl/vec_seq_pkg.sv
// Shared types and sizes for the vec_seq sweep sequencer.
package vec_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NUM_VEC  = 16;
   localparam int RESULT_W = 32;

endpackage : vec_seq_pkg

// File: rtl/vec_seq_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the final cycle of each dwell.
module vec_seq_timer #(
   parameter int DWELL = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   // A one-cycle dwell still needs a one-bit counter, which then sits at zero.
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [CW-1:0] cnt;

   assign tc = (cnt == CW'(DWELL - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule : vec_seq_timer

// File: rtl/vec_seq.sv
// Steps {a,b,c,d} through all 16 input vectors, holding each for DWELL cycles, and captures {y,z} per vector.
// Optional registered parity output res_par is built when VEC_SEQ_PARITY_EN is defined.
module vec_seq
   import vec_seq_pkg::*;
#(
   parameter int DWELL = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                y,
   input  logic                z,
   output logic                a,
   output logic                b,
   output logic                c,
   output logic                d,
   output logic                busy,
   output logic                done,
   output logic [3:0]          vec_idx,
   output logic [RESULT_W-1:0] result
`ifdef VEC_SEQ_PARITY_EN
   ,
   output logic                res_par
`endif
);

   state_t state_q, state_d;
   logic   tc;
   logic   start_sweep;
   logic   capture;
   logic   last_vec;

   // start is only honoured outside RUN; a restart from DONE behaves exactly like one from IDLE.
   assign start_sweep = (state_q != RUN) && start;
   assign capture     = (state_q == RUN) && tc;
   assign last_vec    = (vec_idx == 4'(NUM_VEC - 1));

   vec_seq_timer #(
      .DWELL (DWELL)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (start_sweep),
      .enable (state_q == RUN),
      .tc     (tc)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (capture && last_vec) state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // vec_idx wraps from 15 back to 0 on the final capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_idx <= '0;
         result  <= '0;
      end else if (start_sweep) begin
         vec_idx <= '0;
         result  <= '0;
      end else if (capture) begin
         result[{vec_idx, 1'b0} +: 2] <= {y, z};
         vec_idx                      <= vec_idx + 1'b1;
      end
   end

   assign {a, b, c, d} = (state_q == RUN) ? vec_idx : 4'b0000;
   assign busy         = (state_q == RUN);
   assign done         = (state_q == DONE);

`ifdef VEC_SEQ_PARITY_EN
   // result only moves on capture or clear, so tracking it every cycle lands one cycle after each capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_par <= 1'b0;
      end else begin
         res_par <= ^result;
      end
   end
`endif

endmodule : vec_seq

// File: tb/tb_vec_seq.sv
// Scoreboard bench for vec_seq: a DWELL=10 instance with a logic-function responder and a DWELL=1 instance with a constant responder.
module tb_vec_seq;

   typedef struct {
      logic [31:0] res;
      int          cycles;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start10, start1;
   logic        a10, b10, c10, d10, y10, z10, busy10, done10;
   logic        a1, b1, c1, d1, y1, z1, busy1, done1;
   logic [3:0]  vec10, vec1;
   logic [31:0] result10, result1;
   logic        inv10;
   logic        flip1;
`ifdef VEC_SEQ_PARITY_EN
   logic        res_par10, res_par1;
`endif

   int   n_compared   = 0;
   int   n_mismatched = 0;
   exp_t q10[$];
   exp_t q1[$];
   logic [31:0] base_model;

   always #5 clk = ~clk;

   vec_seq #(.DWELL(10)) u_dut10 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start10),
      .y       (y10),
      .z       (z10),
      .a       (a10),
      .b       (b10),
      .c       (c10),
      .d       (d10),
      .busy    (busy10),
      .done    (done10),
      .vec_idx (vec10),
      .result  (result10)
`ifdef VEC_SEQ_PARITY_EN
      ,
      .res_par (res_par10)
`endif
   );

   vec_seq #(.DWELL(1)) u_dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start1),
      .y       (y1),
      .z       (z1),
      .a       (a1),
      .b       (b1),
      .c       (c1),
      .d       (d1),
      .busy    (busy1),
      .done    (done1),
      .vec_idx (vec1),
      .result  (result1)
`ifdef VEC_SEQ_PARITY_EN
      ,
      .res_par (res_par1)
`endif
   );

   // Downstream function blocks
   assign y10 = (a10 ^ b10 ^ c10 ^ d10) ^ inv10;
   assign z10 = ((a10 & b10) | (c10 & d10)) ^ inv10;
   assign y1  = 1'b1;
   assign z1  = flip1 & a1 & b1 & c1 & d1;

   function automatic logic [31:0] modelResult(input logic inv);
      logic [31:0] r;
      logic [3:0]  v;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         v          = 4'(i);
         r[2*i+1]   = (^v) ^ inv;
         r[2*i]     = ((v[3] & v[2]) | (v[1] & v[0])) ^ inv;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pulse start on the selected instance across exactly one rising edge; call at a falling edge.
   task automatic applyStimulus(input int sel);
      if (sel == 10) start10 = 1'b1;
      else           start1  = 1'b1;
      @(negedge clk);
      start10 = 1'b0;
      start1  = 1'b0;
   endtask

   task automatic waitDone(input int sel, input int max_cycles);
      int n = 0;
      while (((sel == 10) ? done10 : done1) !== 1'b1 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      if (sel == 10) checkOutput("wait_done10", {31'd0, done10}, 32'd1);
      else           checkOutput("wait_done1", {31'd0, done1}, 32'd1);
   endtask

   task automatic waitVec10(input logic [3:0] idx, input int max_cycles);
      int n = 0;
      while (vec10 !== idx && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wait_vec10", {28'd0, vec10}, {28'd0, idx});
   endtask

   // Monitor for the DWELL=10 instance: tracks the vector sequence and pops the scoreboard on each completion.
   logic busy10_prev = 1'b0, done10_prev = 1'b0;
   int   busy_cnt10 = 0, vec_err10 = 0;
   always @(negedge clk) begin
      logic [3:0] ev;
      exp_t       e;
      if (busy10) begin
         if (!busy10_prev) begin
            busy_cnt10 = 0;
            vec_err10  = 0;
         end
         ev = 4'(busy_cnt10 / 10);
         if ({a10, b10, c10, d10} !== ev || vec10 !== ev) vec_err10++;
         busy_cnt10++;
      end
      if (done10 && !done10_prev) begin
         if (q10.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_done10: got done with empty scoreboard");
         end else begin
            e = q10.pop_front();
            checkOutput("result10", result10, e.res);
            checkOutput("busy_cycles10", 32'(busy_cnt10), 32'(e.cycles));
            checkOutput("vec_steps10", 32'(vec_err10), 32'd0);
         end
      end
      busy10_prev = busy10;
      done10_prev = done10;
   end

   // Monitor for the DWELL=1 instance
   logic busy1_prev = 1'b0, done1_prev = 1'b0;
   int   busy_cnt1 = 0, vec_err1 = 0;
   always @(negedge clk) begin
      logic [3:0] ev;
      exp_t       e;
      if (busy1) begin
         if (!busy1_prev) begin
            busy_cnt1 = 0;
            vec_err1  = 0;
         end
         ev = 4'(busy_cnt1);
         if ({a1, b1, c1, d1} !== ev || vec1 !== ev) vec_err1++;
         busy_cnt1++;
      end
      if (done1 && !done1_prev) begin
         if (q1.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_done1: got done with empty scoreboard");
         end else begin
            e = q1.pop_front();
            checkOutput("result1", result1, e.res);
            checkOutput("busy_cycles1", 32'(busy_cnt1), 32'(e.cycles));
            checkOutput("vec_steps1", 32'(vec_err1), 32'd0);
         end
      end
      busy1_prev = busy1;
      done1_prev = done1;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      base_model = modelResult(1'b0);
      rst_n   = 1'b0;
      start10 = 1'b0;
      start1  = 1'b0;
      inv10   = 1'b0;
      flip1   = 1'b0;

      #3;
      $display("[TB] reset state");
      checkOutput("rst_busy", {31'd0, busy10}, 32'd0);
      checkOutput("rst_done", {31'd0, done10}, 32'd0);
      checkOutput("rst_abcd", {28'd0, a10, b10, c10, d10}, 32'd0);
      checkOutput("rst_vec", {28'd0, vec10}, 32'd0);
      checkOutput("rst_result", result10, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] DWELL=1 constant responder");
      q1.push_back('{res: 32'hAAAA_AAAA, cycles: 16});
      applyStimulus(1);
      waitDone(1, 40);
`ifdef VEC_SEQ_PARITY_EN
      checkOutput("par1_lag", {31'd0, res_par1}, 32'd1);
      @(negedge clk);
      checkOutput("par1_aaaa", {31'd0, res_par1}, 32'd0);
`endif
      flip1 = 1'b1;
      q1.push_back('{res: 32'hEAAA_AAAA, cycles: 16});
      applyStimulus(1);
      waitDone(1, 40);
`ifdef VEC_SEQ_PARITY_EN
      @(negedge clk);
      checkOutput("par1_flip", {31'd0, res_par1}, 32'd1);
`endif
      flip1 = 1'b0;

      $display("[TB] DWELL=10 full sweep");
      q10.push_back('{res: base_model, cycles: 160});
      applyStimulus(10);
      waitDone(10, 200);
      repeat (5) @(negedge clk);
      checkOutput("hold_result", result10, base_model);
      checkOutput("hold_done", {31'd0, done10}, 32'd1);
      checkOutput("hold_abcd", {28'd0, a10, b10, c10, d10}, 32'd0);
`ifdef VEC_SEQ_PARITY_EN
      checkOutput("par10", {31'd0, res_par10}, {31'd0, ^base_model});
`endif

      $display("[TB] start ignored mid-sweep");
      q10.push_back('{res: base_model, cycles: 160});
      applyStimulus(10);
      waitVec10(4'd5, 100);
      applyStimulus(10);
      checkOutput("midstart_busy", {31'd0, busy10}, 32'd1);
      waitDone(10, 200);

      $display("[TB] restart from DONE with inverted responder");
      @(negedge clk);
      inv10 = 1'b1;
      q10.push_back('{res: ~base_model, cycles: 160});
      applyStimulus(10);
      checkOutput("restart_clear", result10, 32'd0);
      checkOutput("restart_busy", {31'd0, busy10}, 32'd1);
      waitDone(10, 200);
      @(negedge clk);
      inv10 = 1'b0;

      $display("[TB] reset mid-sweep");
      applyStimulus(10);
      waitVec10(4'd7, 100);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", {31'd0, busy10}, 32'd0);
      checkOutput("midrst_done", {31'd0, done10}, 32'd0);
      checkOutput("midrst_abcd", {28'd0, a10, b10, c10, d10}, 32'd0);
      checkOutput("midrst_vec", {28'd0, vec10}, 32'd0);
      checkOutput("midrst_result", result10, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("idle_wait_busy", {31'd0, busy10}, 32'd0);
      checkOutput("idle_wait_done", {31'd0, done10}, 32'd0);
      q10.push_back('{res: base_model, cycles: 160});
      applyStimulus(10);
      waitDone(10, 200);
      repeat (2) @(negedge clk);

      if (q10.size() != 0 || q1.size() != 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", q10.size() + q1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule : tb_vec_seq

// File: doc/vec_seq.md
VEC_SEQ -- requirements
Module: vec_seq

Interface
REQ-001 Parameter DWELL, default 10: cycles each input vector is held; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle or level request to begin a sweep; sampled on rising edge.
REQ-005 a, b, c, d  output  1 each  stimulus to the downstream 4-input function block.
REQ-006 y, z  input  1 each  function block responses.
REQ-007 busy  output  1  high while a sweep runs.
REQ-008 done  output  1  high from sweep completion until the next start or reset.
REQ-009 vec_idx  output  4  index of the vector currently driven.
REQ-010 result  output  32  captured responses; bits [2i+1:2i] = {y,z} for vector i.

Function
REQ-011 The block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE with start=1 SHALL go to RUN next edge, clearing vec_idx, the dwell counter and result to 0.
REQ-013 {a,b,c,d} SHALL equal vec_idx[3:0] (a = MSB) in RUN, and 4'b0000 in IDLE and DONE.
REQ-014 In RUN the dwell counter SHALL increment each cycle from 0 to DWELL-1.
REQ-015 At the edge where counter = DWELL-1, {y,z} SHALL be written into result[2*vec_idx+1 : 2*vec_idx], the counter SHALL return to 0 and vec_idx SHALL increment.
REQ-016 Capture of vector 15 SHALL move the FSM to DONE; vec_idx SHALL wrap to 0.
REQ-017 Each vector SHALL be held exactly DWELL cycles; a sweep SHALL occupy exactly 16*DWELL cycles in RUN.
REQ-018 busy SHALL be high only in RUN; done SHALL be high only in DONE.
REQ-019 start in RUN SHALL be ignored.
REQ-020 start in DONE SHALL restart exactly as from IDLE (REQ-012) on the next edge.
REQ-021 result SHALL hold its value in DONE and IDLE; it SHALL change only by capture or clear.
REQ-022 With DWELL=1, capture SHALL occur every RUN cycle and vec_idx SHALL advance every cycle.

Reset
REQ-023 With rst_n low: FSM=IDLE, counter=0, vec_idx=0, result=0, a/b/c/d=0, busy=0, done=0, taking effect immediately.
REQ-024 Reset asserted mid-sweep SHALL discard the partial result; after release the block SHALL wait in IDLE for start.

Configuration
REQ-025 Macro VEC_SEQ_PARITY_EN: when defined, an extra output res_par (1 bit) SHALL equal the XOR of all 32 result bits, registered, updated the cycle after each capture, and reset to 0.
REQ-026 When VEC_SEQ_PARITY_EN is undefined, res_par and its logic SHALL not exist; all other behaviour is identical.

Structure
REQ-027 A shared package vec_seq_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE), NUM_VEC=16 and RESULT_W=32.
REQ-028 The dwell counter SHALL be a sub-module, vec_seq_timer (inputs: clear, enable; output: terminal count at DWELL-1; width $clog2(DWELL)).

Verification
REQ-029 DWELL=10, responder y=a^b^c^d, z=a&b|c&d, one start pulse -> busy exactly 160 cycles, {a,b,c,d} steps 0..15 each held 10 cycles, done=1, result equals the model value.
REQ-030 DWELL=1, constant y=1, z=0 -> busy 16 cycles, result=32'hAAAA_AAAA.
REQ-031 start pulsed again at vector 5 mid-sweep -> no restart, total busy still 16*DWELL, result unchanged from the single-start run.
REQ-032 rst_n low at vector 7 -> outputs 0 immediately, result=0; release, then start -> clean full sweep.
REQ-033 Start in DONE with inverted responder -> result cleared at restart, final result is the bitwise complement of the previous sweep.
REQ-034 VEC_SEQ_PARITY_EN defined, result=32'hAAAA_AAAA -> res_par=0; one flipped bit -> res_par=1 one cycle after that capture.
